// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches under a credit limit, tracks
// fixed-latency memory returns, and supports branch/fork redirect and core halt flushes.
module fetch_queue #(
    parameter int                ADDR_W   = 16,
    parameter int                INS_W    = 16,
    parameter int                QDEPTH   = 4,
    parameter int                MEM_LAT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_en,
    input  logic                  branch_en,
    input  logic [ADDR_W-1:0]     branch_val,
    input  logic [2*ADDR_W:0]     fork_cxt,
    input  logic                  stall,
    output logic                  fetch_req,
    output logic [ADDR_W-1:0]     fetch_addr,
    input  logic [INS_W-1:0]      fetch_data,
    output logic [INS_W-1:0]      ins,
    output logic                  ins_valid,
    output logic [ADDR_W-1:0]     ins_pc
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 4;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [MEM_LAT-1:0] infl_v_q, infl_v_d;
    logic [ADDR_W-1:0]  infl_pc_q [MEM_LAT];
    logic [ADDR_W-1:0]  infl_pc_d [MEM_LAT];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [INS_W-1:0]   ins_mem_q [QDEPTH];
    logic [ADDR_W-1:0]  pc_mem_q  [QDEPTH];

    logic               redirect;
    logic [ADDR_W-1:0]  target;
    logic               flush;
    logic               issue;
    logic               push;
    logic               pop;
    logic [3:0]         infl_cnt;
    logic [SUM_W-1:0]   credit_used;

    // Only the target field of the fork context is meaningful here.
    logic               unused_fork_hi;
    assign unused_fork_hi = ^fork_cxt[2*ADDR_W-1:ADDR_W];

    assign redirect = branch_en | fork_cxt[2*ADDR_W];
    assign target   = branch_en ? branch_val : fork_cxt[ADDR_W-1:0];
    assign flush    = redirect | ~core_en;

    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            infl_cnt = infl_cnt + 4'(infl_v_q[i]);
        end
    end

    // Queued plus outstanding requests may never exceed the queue size,
    // so a return can always be written without overflow.
    assign credit_used = SUM_W'(count_q) + SUM_W'(infl_cnt);
    assign issue       = core_en & ~redirect & (credit_used < SUM_W'(QDEPTH));

    assign push = infl_v_q[MEM_LAT-1] & ~flush;
    assign pop  = (count_q != '0) & ~stall & ~flush;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = target;
        end else if (issue) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_comb begin
        infl_v_d     = '0;
        infl_v_d[0]  = issue;
        infl_pc_d[0] = pc_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            infl_v_d[i]  = infl_v_q[i-1] & ~flush;
            infl_pc_d[i] = infl_pc_q[i-1];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            infl_v_q <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                infl_pc_q[i] <= '0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            infl_v_q <= infl_v_d;
            for (int i = 0; i < MEM_LAT; i++) begin
                infl_pc_q[i] <= infl_pc_d[i];
            end
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: validity comes solely from count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem_q[tail_q] <= fetch_data;
            pc_mem_q[tail_q]  <= infl_pc_q[MEM_LAT-1];
        end
    end

    assign fetch_req  = issue & rst_n;
    assign fetch_addr = pc_q;
    assign ins_valid  = (count_q != '0);
    assign ins        = ins_valid ? ins_mem_q[head_q] : '0;
    assign ins_pc     = ins_valid ? pc_mem_q[head_q]  : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue: one row per clock cycle, memory model
// returns (address ^ 0x5A5A) exactly MEM_LAT cycles after each request.
module tb_fetch_queue;

    localparam int MEM_LAT = 2;

    typedef struct {
        bit          ce;
        bit          br;
        logic [15:0] bv;
        bit          fv;
        logic [15:0] ft;
        bit          st;
        bit          req;
        logic [15:0] addr;
        bit          vld;
        logic [15:0] pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_en;
    logic        branch_en;
    logic [15:0] branch_val;
    logic [32:0] fork_cxt;
    logic        stall;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic [15:0] fetch_data;
    logic [15:0] ins;
    logic        ins_valid;
    logic [15:0] ins_pc;

    logic [15:0] hist [MEM_LAT];
    int          n_vec  = 0;
    int          n_fail = 0;
    vec_t        tbl [23];

    fetch_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_en    (core_en),
        .branch_en  (branch_en),
        .branch_val (branch_val),
        .fork_cxt   (fork_cxt),
        .stall      (stall),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_pc     (ins_pc)
    );

    always #5 clk = ~clk;

    function automatic vec_t row(bit ce, bit br, logic [15:0] bv, bit fv, logic [15:0] ft,
                                 bit st, bit req, logic [15:0] addr, bit vld, logic [15:0] pc);
        vec_t r;
        r.ce = ce; r.br = br; r.bv = bv; r.fv = fv; r.ft = ft; r.st = st;
        r.req = req; r.addr = addr; r.vld = vld; r.pc = pc;
        return r;
    endfunction

    task automatic check_now(string name, bit req, logic [15:0] addr, bit vld, logic [15:0] pc);
        logic [15:0] exp_ins;
        logic [15:0] exp_pc;
        exp_ins = vld ? (pc ^ 16'h5A5A) : 16'h0000;
        exp_pc  = vld ? pc : 16'h0000;
        n_vec++;
        if (fetch_req !== req || (req && fetch_addr !== addr) || ins_valid !== vld ||
            ins !== exp_ins || ins_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL %s: got req=%b addr=%h vld=%b ins=%h pc=%h, expected req=%b addr=%h vld=%b ins=%h pc=%h",
                     name, fetch_req, fetch_addr, ins_valid, ins, ins_pc, req, addr, vld, exp_ins, exp_pc);
        end else begin
            $display("%s: req=%b addr=%h vld=%b ins=%h pc=%h",
                     name, fetch_req, fetch_addr, ins_valid, ins, ins_pc);
        end
    endtask

    // Memory model: data for this edge belongs to the request MEM_LAT cycles back;
    // it is returned regardless of cancellation so stale data is always present.
    task automatic tick();
        fetch_data = hist[MEM_LAT-1] ^ 16'h5A5A;
        for (int i = MEM_LAT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = fetch_addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply(string name, vec_t t);
        core_en    = t.ce;
        branch_en  = t.br;
        branch_val = t.bv;
        fork_cxt   = {t.fv, 16'hDEAD, t.ft};
        stall      = t.st;
        #1;
        check_now(name, t.req, t.addr, t.vld, t.pc);
        tick();
    endtask

    initial begin
        // Reset-release stream, then a 10-cycle stall and its release.
        tbl[0]  = row(1,0,0,0,0,0, 1,16'h0000, 0,16'h0000);
        tbl[1]  = row(1,0,0,0,0,0, 1,16'h0001, 0,16'h0000);
        tbl[2]  = row(1,0,0,0,0,0, 1,16'h0002, 0,16'h0000);
        tbl[3]  = row(1,0,0,0,0,0, 1,16'h0003, 1,16'h0000);
        tbl[4]  = row(1,0,0,0,0,0, 1,16'h0004, 1,16'h0001);
        tbl[5]  = row(1,0,0,0,0,0, 1,16'h0005, 1,16'h0002);
        tbl[6]  = row(1,0,0,0,0,0, 1,16'h0006, 1,16'h0003);
        tbl[7]  = row(1,0,0,0,0,0, 1,16'h0007, 1,16'h0004);
        tbl[8]  = row(1,0,0,0,0,1, 1,16'h0008, 1,16'h0005);
        for (int i = 9; i <= 17; i++) tbl[i] = row(1,0,0,0,0,1, 0,16'h0000, 1,16'h0005);
        tbl[18] = row(1,0,0,0,0,0, 0,16'h0000, 1,16'h0005);
        tbl[19] = row(1,0,0,0,0,0, 1,16'h0009, 1,16'h0006);
        tbl[20] = row(1,0,0,0,0,0, 1,16'h000A, 1,16'h0007);
        tbl[21] = row(1,0,0,0,0,0, 1,16'h000B, 1,16'h0008);
        tbl[22] = row(1,0,0,0,0,0, 1,16'h000C, 1,16'h0009);

        for (int i = 0; i < MEM_LAT; i++) hist[i] = 16'h0000;
        fetch_data = 16'h0000;
        rst_n      = 1'b0;
        @(negedge clk);
        apply("reset0", row(1,0,0,0,0,0, 0,0, 0,0));
        apply("reset1", row(1,0,0,0,0,0, 0,0, 0,0));
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) apply($sformatf("main[%0d]", i), tbl[i]);

        // Branch under stall with entries queued and requests in flight.
        apply("br_pre",   row(1,0,16'h0000,0,0,1, 1,16'h000D, 1,16'h000A));
        apply("br_hit",   row(1,1,16'h0100,0,0,1, 0,16'h0000, 1,16'h000A));
        apply("br_t1",    row(1,0,0,0,0,0, 1,16'h0100, 0,0));
        apply("br_t2",    row(1,0,0,0,0,0, 1,16'h0101, 0,0));
        apply("br_t3",    row(1,0,0,0,0,0, 1,16'h0102, 0,0));
        apply("br_t4",    row(1,0,0,0,0,0, 1,16'h0103, 1,16'h0100));

        // Branch and fork together: branch target wins.
        apply("bf_hit",   row(1,1,16'h0040,1,16'h0200,0, 0,0, 1,16'h0101));
        apply("bf_t1",    row(1,0,0,0,0,0, 1,16'h0040, 0,0));
        apply("bf_t2",    row(1,0,0,0,0,0, 1,16'h0041, 0,0));
        apply("bf_t3",    row(1,0,0,0,0,0, 1,16'h0042, 0,0));
        apply("bf_t4",    row(1,0,0,0,0,0, 1,16'h0043, 1,16'h0040));

        // Fork alone.
        apply("fk_hit",   row(1,0,16'h0999,1,16'h0200,0, 0,0, 1,16'h0041));
        apply("fk_t1",    row(1,0,0,0,0,0, 1,16'h0200, 0,0));
        apply("fk_t2",    row(1,0,0,0,0,0, 1,16'h0201, 0,0));
        apply("fk_t3",    row(1,0,0,0,0,0, 1,16'h0202, 0,0));
        apply("fk_t4",    row(1,0,0,0,0,0, 1,16'h0203, 1,16'h0200));

        // PC wrap from all-ones.
        apply("wr_hit",   row(1,1,16'hFFFF,0,0,0, 0,0, 1,16'h0201));
        apply("wr_t1",    row(1,0,0,0,0,0, 1,16'hFFFF, 0,0));
        apply("wr_t2",    row(1,0,0,0,0,0, 1,16'h0000, 0,0));
        apply("wr_t3",    row(1,0,0,0,0,0, 1,16'h0001, 0,0));
        apply("wr_t4",    row(1,0,0,0,0,0, 1,16'h0002, 1,16'hFFFF));
        apply("wr_t5",    row(1,0,0,0,0,0, 1,16'h0003, 1,16'h0000));

        // Core disable for 5 cycles, then resume at the held PC.
        apply("ce_off0",  row(0,0,0,0,0,0, 0,0, 1,16'h0001));
        for (int i = 1; i < 5; i++) apply($sformatf("ce_off%0d", i), row(0,0,0,0,0,0, 0,0, 0,0));
        apply("ce_on1",   row(1,0,0,0,0,0, 1,16'h0004, 0,0));
        apply("ce_on2",   row(1,0,0,0,0,0, 1,16'h0005, 0,0));
        apply("ce_on3",   row(1,0,0,0,0,0, 1,16'h0006, 0,0));

        // Asynchronous reset mid-cycle while the head is valid.
        #1;
        check_now("pre_rst", 1, 16'h0007, 1, 16'h0004);
        rst_n = 1'b0;
        #1;
        check_now("async_rst", 0, 16'h0000, 0, 16'h0000);
        tick();
        apply("in_rst0",  row(1,0,0,0,0,0, 0,0, 0,0));
        apply("in_rst1",  row(1,0,0,0,0,0, 0,0, 0,0));
        rst_n = 1'b1;
        apply("post_rst0", row(1,0,0,0,0,0, 1,16'h0000, 0,0));
        apply("post_rst1", row(1,0,0,0,0,0, 1,16'h0001, 0,0));
        apply("post_rst2", row(1,0,0,0,0,0, 1,16'h0002, 0,0));
        apply("post_rst3", row(1,0,0,0,0,0, 1,16'h0003, 1,16'h0000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
